// File: rtl/question_builder_if.sv
// Request/result bundle between the setup logic and the question-bank builder.
// The requesting side uses the master modport; the builder uses the slave modport.
interface question_builder_if #(
  parameter int MAX_Q = 50
);
  logic                   start;
  logic [5:0]             total;
  logic [4:0]             cat_mask;
  logic [15:0]            seed;
  logic [21*MAX_Q-1:0]    mode_question_flat;
  logic [5:0]             q_count;
  logic                   busy;
  logic                   done;

  modport master (
    output start, total, cat_mask, seed,
    input  mode_question_flat, q_count, busy, done
  );

  modport slave (
    input  start, total, cat_mask, seed,
    output mode_question_flat, q_count, busy, done
  );
endinterface

// File: rtl/question_builder.sv
// Builds the competition question bank: one LFSR-derived 21-bit slot per clock,
// categories rotated through the enabled set; the bank holds until the next start.
module question_builder #(
  parameter int          MAX_Q    = 50,
  parameter logic [15:0] SEED_DEF = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 reset,
  question_builder_if.slave    bus
);

  localparam int W = 21 * MAX_Q;

  typedef enum logic [1:0] {IDLE, LOAD, GEN, DONE} state_t;

  state_t        state;
  logic [5:0]    total_eff;
  logic [4:0]    mask_eff;
  logic [15:0]   seed_eff;
  logic [15:0]   lfsr;
  logic [5:0]    idx;
  logic [2:0]    cat_ptr;
  logic [W-1:0]  flat;
  logic [5:0]    q_count;
  logic          busy;
  logic          done;

  logic [15:0]   nxt;
  logic [2:0]    cand;
  logic [2:0]    chosen;
  logic          found;
  logic [1:0]    op;
  logic [7:0]    opa;
  logic [7:0]    opb;
  logic [20:0]   slot;
  logic [2:0]    next_ptr;

  // Slot contents for the current GEN cycle, all derived from the next LFSR value.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    nxt    = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    chosen = 3'd0;
    found  = 1'b0;
    cand   = 3'd0;
    for (int i = 0; i < 5; i++) begin
      cand = 3'((int'(cat_ptr) + i) % 5);
      if (!found && mask_eff[cand]) begin
        found  = 1'b1;
        chosen = cand;
      end
    end

    op  = nxt[1:0];
    opa = nxt[7:0];
    opb = nxt[15:8];
    case (chosen)
      3'd0:    if (op == 2'd3) op = 2'd2;     // base convert has only three ops
      3'd1:    op = {1'b0, nxt[0]};           // add/sub only
      3'd2:    opb = {5'b0, nxt[10:8]};       // shift amount 0..7
      default: ;
    endcase

    slot     = {chosen + 3'd1, op, opa, opb};
    next_ptr = (chosen == 3'd4) ? 3'd0 : chosen + 3'd1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      total_eff <= 6'd1;
      mask_eff  <= 5'h1F;
      seed_eff  <= SEED_DEF;
      lfsr      <= SEED_DEF;
      idx       <= 6'd0;
      cat_ptr   <= 3'd0;
      // NOTE: the bank is a plain register vector, reset so the answer block never sees stale slots.
      flat      <= '0;
      q_count   <= 6'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.start) begin
            if (bus.total == 6'd0)
              total_eff <= 6'd1;
            else if (bus.total > 6'(MAX_Q))
              total_eff <= 6'(MAX_Q);
            else
              total_eff <= bus.total;
            mask_eff <= (bus.cat_mask == 5'd0) ? 5'h1F : bus.cat_mask;
            seed_eff <= (bus.seed == 16'd0) ? SEED_DEF : bus.seed;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end

        LOAD: begin
          lfsr    <= seed_eff;
          idx     <= 6'd0;
          cat_ptr <= 3'd0;
          q_count <= 6'd0;
          flat    <= '0;
          state   <= GEN;
        end

        GEN: begin
          flat[int'(idx)*21 +: 21] <= slot;
          lfsr    <= nxt;
          cat_ptr <= next_ptr;
          idx     <= idx + 6'd1;
          q_count <= idx + 6'd1;
          if (idx == total_eff - 6'd1) begin
            // done is registered here so it is visible for exactly the DONE cycle.
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mode_question_flat = flat;
  assign bus.q_count            = q_count;
  assign bus.busy               = busy;
  assign bus.done               = done;

endmodule

// File: tb/tb_question_builder.sv
// Directed bench for question_builder: table of builds with hand-computed first slots,
// plus hand-written sequences for rotation, clamping, mid-build start and reset abort.
module tb_question_builder;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  question_builder_if #(.MAX_Q(50)) bus ();

  question_builder #(.MAX_Q(50), .SEED_DEF(16'hACE1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [5:0]  total;
    logic [4:0]  mask;
    logic [15:0] seed;
    logic [5:0]  exp_q;
    logic [20:0] exp_slot0;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1049:0] ref_bank(input int t, input logic [4:0] m, input logic [15:0] s);
    logic [1049:0] bank;
    logic [15:0]   r, nx;
    logic [4:0]    me;
    logic [1:0]    op;
    logic [7:0]    a, b;
    int            n_q, ptr, cat;
    bank = '0;
    n_q  = (t == 0) ? 1 : ((t > 50) ? 50 : t);
    me   = (m == 5'd0) ? 5'h1F : m;
    r    = (s == 16'd0) ? 16'hACE1 : s;
    ptr  = 0;
    for (int k = 0; k < n_q; k++) begin
      nx  = {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
      cat = ptr;
      while (!me[cat]) cat = (cat + 1) % 5;
      op = nx[1:0];
      a  = nx[7:0];
      b  = nx[15:8];
      if (cat == 0 && op == 2'd3) op = 2'd2;
      if (cat == 1) op[1] = 1'b0;
      if (cat == 2) b[7:3] = 5'b0;
      bank[k*21 +: 21] = {3'(cat + 1), op, a, b};
      ptr = (cat + 1) % 5;
      r   = nx;
    end
    return bank;
  endfunction

  task automatic check_bank(input string name, input logic [1049:0] exp);
    tests++;
    if (bus.mode_question_flat !== exp) begin
      failed++;
      for (int k = 0; k < 50; k++) begin
        if (bus.mode_question_flat[k*21 +: 21] !== exp[k*21 +: 21]) begin
          $display("FAIL %s: slot %0d got %0h expected %0h", name, k,
                   bus.mode_question_flat[k*21 +: 21], exp[k*21 +: 21]);
          break;
        end
      end
    end
  endtask

  // Leaves the bench at the first falling edge after the accepting rising edge.
  task automatic start_build(input logic [5:0] t, input logic [4:0] m, input logic [15:0] s);
    @(negedge clk);
    bus.total    = t;
    bus.cat_mask = m;
    bus.seed     = s;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  // lat counts falling-edge samples after the start edge, the first being 1.
  task automatic wait_done(output int lat, output int busy_cycles);
    lat = 1;
    busy_cycles = 0;
    while (!bus.done && lat < 200) begin
      if (bus.busy) busy_cycles++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, bcnt, dones, first;
    logic [1049:0] exp_bank;

    bus.start    = 1'b0;
    bus.total    = 6'd0;
    bus.cat_mask = 5'd0;
    bus.seed     = 16'd0;

    vecs[0] = '{6'd1, 5'h1F, 16'h0000, 6'd1, 21'h06C359};
    vecs[1] = '{6'd3, 5'h08, 16'h0000, 6'd3, 21'h13C359};
    vecs[2] = '{6'd2, 5'h02, 16'h0000, 6'd2, 21'h09C359};
    vecs[3] = '{6'd4, 5'h04, 16'h0000, 6'd4, 21'h0FC301};
    vecs[4] = '{6'd0, 5'h10, 16'h0000, 6'd1, 21'h17C359};
    vecs[5] = '{6'd5, 5'h1F, 16'h0001, 6'd5, 21'h060200};
    vecs[6] = '{6'd0, 5'h00, 16'h0001, 6'd1, 21'h060200};

    // Reset state
    #12;
    check("reset_flat_zero", 64'(bus.mode_question_flat != '0), 64'd0);
    check("reset_q_count", 64'(bus.q_count), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Table-driven builds
    for (int v = 0; v < 7; v++) begin
      start_build(vecs[v].total, vecs[v].mask, vecs[v].seed);
      wait_done(lat, bcnt);
      check($sformatf("v%0d_latency", v), 64'(lat), 64'(vecs[v].exp_q) + 64'd2);
      check($sformatf("v%0d_q_count", v), 64'(bus.q_count), 64'(vecs[v].exp_q));
      check($sformatf("v%0d_slot0", v), 64'(bus.mode_question_flat[20:0]), 64'(vecs[v].exp_slot0));
      check_bank($sformatf("v%0d_bank", v), ref_bank(int'(vecs[v].total), vecs[v].mask, vecs[v].seed));
      @(negedge clk);
      check($sformatf("v%0d_done_width", v), 64'(bus.done), 64'd0);
    end

    // Full build: category rotation, busy length, single-cycle done
    start_build(6'd50, 5'h1F, 16'h0000);
    wait_done(lat, bcnt);
    check("full_latency", 64'(lat), 64'd52);
    check("full_busy_cycles", 64'(bcnt), 64'd51);
    check("full_q_count", 64'(bus.q_count), 64'd50);
    for (int k = 0; k < 10; k++)
      check($sformatf("full_cat_slot%0d", k), 64'(bus.mode_question_flat[k*21+18 +: 3]), 64'((k % 5) + 1));
    check_bank("full_bank", ref_bank(50, 5'h1F, 16'h0000));
    @(negedge clk);
    check("full_done_width", 64'(bus.done), 64'd0);

    // Shift-only bank, then a rebuild with total=0
    start_build(6'd8, 5'h04, 16'h3C5A);
    wait_done(lat, bcnt);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("shift_cat_slot%0d", k), 64'(bus.mode_question_flat[k*21+18 +: 3]), 64'd3);
      check($sformatf("shift_b_le_7_slot%0d", k), 64'(bus.mode_question_flat[k*21+3 +: 5]), 64'd0);
    end
    start_build(6'd0, 5'h04, 16'h3C5A);
    wait_done(lat, bcnt);
    check("zero_total_q_count", 64'(bus.q_count), 64'd1);
    check("zero_total_rest_empty", 64'(bus.mode_question_flat[1049:21] != '0), 64'd0);

    // Clamp to 50 with a start pulse and input changes while busy
    start_build(6'd63, 5'h1F, 16'h1234);
    dones = 0;
    first = 0;
    for (int n = 1; n <= 130; n++) begin
      if (bus.done) begin
        dones++;
        if (first == 0) first = n;
      end
      if (n == 10) begin
        bus.start    = 1'b1;
        bus.seed     = 16'hFFFF;
        bus.total    = 6'd5;
        bus.cat_mask = 5'h01;
      end
      if (n == 11) bus.start = 1'b0;
      @(negedge clk);
    end
    check("clamp_latency", 64'(first), 64'd52);
    check("clamp_done_count", 64'(dones), 64'd1);
    check("clamp_q_count", 64'(bus.q_count), 64'd50);
    check_bank("clamp_bank", ref_bank(63, 5'h1F, 16'h1234));

    // Reset during GEN at idx 20
    start_build(6'd50, 5'h1F, 16'hBEEF);
    repeat (21) @(negedge clk);
    check("abort_q_count_before", 64'(bus.q_count), 64'd20);
    reset = 1'b0;
    #1;
    check("abort_flat_zero", 64'(bus.mode_question_flat != '0), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_q_count", 64'(bus.q_count), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    dones = 0;
    for (int n = 0; n < 70; n++) begin
      if (bus.done) dones++;
      @(negedge clk);
    end
    check("abort_no_done", 64'(dones), 64'd0);
    start_build(6'd50, 5'h1F, 16'hBEEF);
    wait_done(lat, bcnt);
    check("rebuild_latency", 64'(lat), 64'd52);
    exp_bank = ref_bank(50, 5'h1F, 16'hBEEF);
    check_bank("rebuild_bank", exp_bank);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
